// File: rtl/div_pkg.sv
// Shared types and default sizes for the sequential restoring divider.
// COUNT_W is the width of the bit counter that walks the dividend MSB to LSB.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int COUNT_W = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand and result handshake bundle for the divider.
// The slave modport is the divider side; master is the producer/consumer side.
interface seq_restoring_divider_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational so it can be replicated for an unrolled or pipelined divider.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] r_o,
  output logic                 q_o
);

  // The shifted value needs one extra bit, otherwise the compare could wrap.
  logic [DIVISOR_W:0] t;

  always_comb begin
    t   = {r_i, bit_i};
    q_o = (t >= {1'b0, divisor_i});
    r_o = q_o ? DIVISOR_W'(t - {1'b0, divisor_i}) : t[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Valid/ready on both sides; no overlap between operations.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W-1:0]  step_r;
  logic                  step_q;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_i       (r_q),
    .bit_i     (q_q[DIVIDEND_W-1]),
    .divisor_i (dsr_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dsr_d   = dsr_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dsr_d = bus.divisor;
          if (bus.divisor == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = bus.dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            q_d     = bus.dividend;
            r_d     = '0;
            cnt_d   = CNT_W'(DIVIDEND_W - 1);
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        // Q doubles as the dividend shifter and the quotient accumulator.
        q_d = {q_q[DIVIDEND_W-2:0], step_q};
        r_d = step_r;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dsr_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dsr_q   <= dsr_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized bench for seq_restoring_divider against an arithmetic model.
module tb_seq_restoring_divider;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_restoring_divider_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

  seq_restoring_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; expected values are supplied by the caller.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic ez,
                        input int chk_lat, input int hold, input bit junk,
                        input string tag);
    int lat;
    lat = 0;
    while (!bus.in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (junk) begin
        bus.in_valid = 1'($urandom);
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, ":out_valid"}, 32'(bus.out_valid), 32'd1);
    if (chk_lat > 0) check({tag, ":latency"}, 32'(lat), 32'(chk_lat));
    check({tag, ":quotient"}, 32'(bus.quotient), 32'(eq));
    check({tag, ":remainder"}, 32'(bus.remainder), 32'(er));
    check({tag, ":div_by_zero"}, 32'(bus.div_by_zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
      end
      @(posedge clk); #1;
      check({tag, ":hold"},
            32'({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero}),
            32'({1'b1, 1'b0, eq, er, ez}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ":drain"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] x;
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          32'({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero}),
          32'({1'b1, 1'b0, 16'h0, 8'h0, 1'b0}));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17, 0, 1'b0, "ffff_ff");
    run_op(16'd1000, 8'd7, 16'h008E, 8'h06, 1'b0, 17, 0, 1'b0, "1000_7");
    run_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1, 0, 1'b0, "div0");
    run_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17, 10, 1'b1, "5_9_backpressure");
    run_op(16'd0, 8'd13, 16'd0, 8'd0, 1'b0, 17, 0, 1'b0, "zero_dividend");
    run_op(16'hBEEF, 8'd1, 16'hBEEF, 8'd0, 1'b0, 17, 0, 1'b0, "divisor_one");
    run_op(16'd0, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1, 2, 1'b0, "zero_by_zero");

    // Reset in the middle of a calculation.
    bus.in_valid = 1'b1;
    bus.dividend = 16'hABCD;
    bus.divisor  = 8'h17;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_calc_reset",
          32'({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero}),
          32'({1'b1, 1'b0, 16'h0, 8'h0, 1'b0}));
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    run_op(16'd200, 8'd3, 16'd66, 8'd2, 1'b0, 17, 0, 1'b0, "200_3");

    for (int n = 0; n < 1500; n++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if (b == 8'd0)
        run_op(a, b, 16'hFFFF, a[7:0], 1'b1, 1, $urandom_range(0, 3), 1'b1, "rand");
      else
        run_op(a, b, a / b, 8'(a % b), 1'b0, 17, $urandom_range(0, 3), 1'b1, "rand");
    end

    for (int n = 0; n < 500; n++) begin
      b = 8'($urandom_range(1, 255));
      x = 16'($urandom_range(0, 65535 / int'(b)));
      run_op(16'(x * b), b, x, 8'd0, 1'b0, 17, $urandom_range(0, 2), 1'b1, "roundtrip");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
